// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the multi-cycle datapath sequencer:
// stage indices, sequencer state encoding and default counter width.
package cpu_ctrl_pkg;

  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

  localparam int DEF_CNT_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } seq_state_e;

endpackage

// File: rtl/next_stage_finder.sv
// Priority encoder: lowest unskipped stage above the current one, or wrap
// when the current stage is the last one the instruction needs.
module next_stage_finder #(
  parameter int NUM_STAGES = 5,
  parameter int IDX_W      = $clog2(NUM_STAGES)
) (
  input  logic [IDX_W-1:0]      cur_idx_i,
  input  logic [NUM_STAGES-1:0] skip_i,
  output logic [IDX_W-1:0]      nxt_idx_o,
  output logic                  wrap_o
);

  // Scan downward so the lowest qualifying index is the last one written.
  always_comb begin
    nxt_idx_o = '0;
    wrap_o    = 1'b1;
    for (int j = NUM_STAGES - 1; j > 0; j--) begin
      if (j > int'(cur_idx_i) && !skip_i[j]) begin
        nxt_idx_o = IDX_W'(j);
        wrap_o    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/multicycle_stage_sequencer.sv
// One-instruction-at-a-time stage sequencer: walks the active stage through
// the ring honouring skip, ready-stall, flush and run, with perf counters.
module multicycle_stage_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          run,
  input  logic [NUM_STAGES-1:0]         stage_skip,
  input  logic [NUM_STAGES-1:0]         stage_ready,
  input  logic                          flush,
  output logic [NUM_STAGES-1:0]         stage_go,
  output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
  output logic                          busy,
  output logic                          instr_done,
  output logic [CNT_W-1:0]              retired_count,
  output logic [CNT_W-1:0]              stall_count
);

  localparam int IDX_W = $clog2(NUM_STAGES);
  localparam logic [NUM_STAGES-1:0] GO_ONE = NUM_STAGES'(1);

  seq_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_STAGES-1:0]   go_q, go_d;
  logic                    done_q, done_d;
  logic [CNT_W-1:0]        retired_q, stall_q;
  logic                    ret_inc, stall_inc;
  logic [IDX_W-1:0]        nxt_idx;
  logic                    wrap;

  next_stage_finder #(
    .NUM_STAGES (NUM_STAGES),
    .IDX_W      (IDX_W)
  ) u_finder (
    .cur_idx_i (idx_q),
    .skip_i    (stage_skip),
    .nxt_idx_o (nxt_idx),
    .wrap_o    (wrap)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    ret_inc   = 1'b0;
    stall_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = ACTIVE;
          idx_d   = '0;
        end
      end
      ACTIVE: begin
        // Flush in fetch has nothing to abort, so it is ignored there.
        if (flush && idx_q != '0) begin
          state_d = run ? ACTIVE : IDLE;
          idx_d   = '0;
        end else if (stage_ready[idx_q]) begin
          if (wrap) begin
            done_d  = 1'b1;
            ret_inc = 1'b1;
            state_d = run ? ACTIVE : IDLE;
            idx_d   = '0;
          end else begin
            idx_d = nxt_idx;
          end
        end else begin
          stall_inc = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    go_d = (state_d == ACTIVE) ? (GO_ONE << idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      go_q      <= '0;
      done_q    <= 1'b0;
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      go_q    <= go_d;
      done_q  <= done_d;
      if (ret_inc)   retired_q <= retired_q + CNT_W'(1);
      if (stall_inc) stall_q   <= stall_q + CNT_W'(1);
    end
  end

  assign stage_go      = go_q;
  assign stage_idx     = idx_q;
  assign busy          = (state_q == ACTIVE);
  assign instr_done    = done_q;
  assign retired_count = retired_q;
  assign stall_count   = stall_q;

endmodule

// File: tb/tb_multicycle_stage_sequencer.sv
// Directed bench for the stage sequencer; a second narrow-counter instance
// shares the stimulus to exercise counter wrap.
module tb_multicycle_stage_sequencer;

  localparam int NS = 5;

  logic          clk = 1'b0;
  logic          nreset, run, flush;
  logic [NS-1:0] stage_skip, stage_ready;
  logic [NS-1:0] stage_go, go_w;
  logic [2:0]    stage_idx, idx_w;
  logic          busy, busy_w, instr_done, done_w;
  logic [31:0]   retired_count, stall_count;
  logic [1:0]    ret_w, stall_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_stage_sequencer #(.NUM_STAGES(NS), .CNT_W(32)) dut (
    .clk(clk), .nreset(nreset), .run(run), .stage_skip(stage_skip),
    .stage_ready(stage_ready), .flush(flush), .stage_go(stage_go),
    .stage_idx(stage_idx), .busy(busy), .instr_done(instr_done),
    .retired_count(retired_count), .stall_count(stall_count)
  );

  multicycle_stage_sequencer #(.NUM_STAGES(NS), .CNT_W(2)) dut_w (
    .clk(clk), .nreset(nreset), .run(run), .stage_skip(stage_skip),
    .stage_ready(stage_ready), .flush(flush), .stage_go(go_w),
    .stage_idx(idx_w), .busy(busy_w), .instr_done(done_w),
    .retired_count(ret_w), .stall_count(stall_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b1; run = 1'b0; flush = 1'b0;
    stage_skip = '0; stage_ready = '1;
    tick(); tick();
    nreset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (stage_go !== 5'h00 || stage_idx !== 3'd0 || busy !== 1'b0 ||
        instr_done !== 1'b0 || retired_count !== 32'd0 || stall_count !== 32'd0) begin
      errors++;
      $display("FAIL reset: go=%h idx=%0d busy=%b done=%b ret=%0d stall=%0d, want all 0",
               stage_go, stage_idx, busy, instr_done, retired_count, stall_count);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || stage_go !== 5'h00) begin
      errors++;
      $display("FAIL idle_hold: busy=%b go=%h, want 0/00", busy, stage_go);
    end
  endtask

  task automatic test_basic();
    logic [NS-1:0] exp_go;
    logic          exp_done;
    do_reset();
    run = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick();
      exp_go   = 5'h01 << ((n - 1) % 5);
      exp_done = (n == 6) || (n == 11);
      checks++;
      if (stage_go !== exp_go || stage_idx !== 3'((n - 1) % 5) ||
          instr_done !== exp_done || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic cyc%0d: go=%h idx=%0d done=%b busy=%b, want go=%h idx=%0d done=%b busy=1",
                 n, stage_go, stage_idx, instr_done, busy, exp_go, (n - 1) % 5, exp_done);
      end
    end
    checks++;
    if (retired_count !== 32'd2 || stall_count !== 32'd0) begin
      errors++;
      $display("FAIL basic_counts: ret=%0d stall=%0d, want 2/0", retired_count, stall_count);
    end
  endtask

  task automatic test_skip();
    logic [NS-1:0] seq [4];
    seq[0] = 5'h01; seq[1] = 5'h02; seq[2] = 5'h04; seq[3] = 5'h10;
    do_reset();
    stage_skip = 5'b01001;  // bit 0 set too: fetch must not be skipped
    run = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      checks++;
      if (stage_go !== seq[(n - 1) % 4] || instr_done !== (n == 5 || n == 9)) begin
        errors++;
        $display("FAIL skip cyc%0d: go=%h done=%b, want go=%h done=%b",
                 n, stage_go, instr_done, seq[(n - 1) % 4], (n == 5 || n == 9));
      end
    end
  endtask

  task automatic test_stall();
    logic [NS-1:0] exp [9];
    exp[0] = 5'h01; exp[1] = 5'h02; exp[2] = 5'h04; exp[3] = 5'h08; exp[4] = 5'h08;
    exp[5] = 5'h08; exp[6] = 5'h08; exp[7] = 5'h10; exp[8] = 5'h01;
    do_reset();
    run = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      stage_ready = (n >= 4 && n <= 6) ? 5'b10111 : 5'b11111;
      checks++;
      if (stage_go !== exp[n - 1] || instr_done !== (n == 9)) begin
        errors++;
        $display("FAIL stall cyc%0d: go=%h done=%b, want go=%h done=%b",
                 n, stage_go, instr_done, exp[n - 1], (n == 9));
      end
    end
    checks++;
    if (stall_count !== 32'd3 || retired_count !== 32'd1) begin
      errors++;
      $display("FAIL stall_counts: stall=%0d ret=%0d, want 3/1", stall_count, retired_count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    run = 1'b1;
    tick(); tick(); tick();  // now in EX
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (stage_go !== 5'h01 || instr_done !== 1'b0 || retired_count !== 32'd0 ||
        stall_count !== 32'd0) begin
      errors++;
      $display("FAIL flush_ex: go=%h done=%b ret=%0d stall=%0d, want 01/0/0/0",
               stage_go, instr_done, retired_count, stall_count);
    end
    flush = 1'b1;  // in IF: no effect
    tick();
    flush = 1'b0;
    checks++;
    if (stage_go !== 5'h02 || stage_idx !== 3'd1) begin
      errors++;
      $display("FAIL flush_if: go=%h idx=%0d, want 02/1", stage_go, stage_idx);
    end
    run = 1'b0; flush = 1'b1;  // flush in ID with run low goes idle
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || stage_go !== 5'h00 || instr_done !== 1'b0 || retired_count !== 32'd0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b go=%h done=%b ret=%0d, want 0/00/0/0",
               busy, stage_go, instr_done, retired_count);
    end
  endtask

  task automatic test_run_drop();
    logic [NS-1:0] exp [3];
    exp[0] = 5'h04; exp[1] = 5'h08; exp[2] = 5'h10;
    do_reset();
    run = 1'b1;
    tick(); tick();  // ID
    run = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (stage_go !== exp[n] || busy !== 1'b1) begin
        errors++;
        $display("FAIL run_drop step%0d: go=%h busy=%b, want %h/1", n, stage_go, busy, exp[n]);
      end
    end
    tick();
    checks++;
    if (instr_done !== 1'b1 || busy !== 1'b0 || stage_go !== 5'h00 || retired_count !== 32'd1) begin
      errors++;
      $display("FAIL run_drop_retire: done=%b busy=%b go=%h ret=%0d, want 1/0/00/1",
               instr_done, busy, stage_go, retired_count);
    end
    tick();
    checks++;
    if (instr_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_drop_idle: done=%b busy=%b, want 0/0", instr_done, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run = 1'b1;
    for (int n = 0; n < 10; n++) tick();  // WB of second instruction
    stage_ready = 5'b01111;
    tick();  // one stall in WB
    checks++;
    if (stage_go !== 5'h10 || retired_count !== 32'd1 || stall_count !== 32'd1) begin
      errors++;
      $display("FAIL pre_reset: go=%h ret=%0d stall=%0d, want 10/1/1",
               stage_go, retired_count, stall_count);
    end
    stage_ready = '1;
    nreset = 1'b1;
    tick();
    checks++;
    if (stage_go !== 5'h00 || stage_idx !== 3'd0 || busy !== 1'b0 || instr_done !== 1'b0 ||
        retired_count !== 32'd0 || stall_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: go=%h idx=%0d busy=%b done=%b ret=%0d stall=%0d, want all 0",
               stage_go, stage_idx, busy, instr_done, retired_count, stall_count);
    end
    nreset = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    run = 1'b1;
    for (int n = 1; n <= 21; n++) begin
      tick();
      if (n == 16) begin
        checks++;
        if (ret_w !== 2'd3) begin
          errors++;
          $display("FAIL wrap_max: ret_w=%0d, want 3", ret_w);
        end
      end
    end
    checks++;
    if (ret_w !== 2'd0 || done_w !== 1'b1 || retired_count !== 32'd4) begin
      errors++;
      $display("FAIL wrap: ret_w=%0d done_w=%b ret=%0d, want 0/1/4", ret_w, done_w, retired_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_stall();
    test_flush();
    test_run_drop();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_stage_sequencer.md
# multicycle_stage_sequencer

Parametrised control sequencer for the multi-cycle ARM datapath. Steps one instruction at a time through `NUM_STAGES` stages (default IF, ID, EX, MEM, WB) and drives a one-hot `stage_go` enable to each stage's pipeline register. Beyond a fixed ring of stages, it adds:
- per-instruction stage skipping;
- multi-cycle stage stalls through a ready handshake;
- branch flush;
- run/idle control;
- retired-instruction and stall-cycle counters.

## Interface
Parameters:
- `NUM_STAGES`, 5, number of stages; legal range 2–16.
- `CNT_W`, 32, width of the performance counters.

Ports:
- `clk`  in  1  clock.
- `nreset`  in  1  reset, synchronous, active-high.
- `run`  in  1  level; 1 = keep issuing instructions, 0 = go idle after the current instruction retires.
- `stage_skip`  in  NUM_STAGES  per-stage skip mask; bit 0 is ignored (fetch is never skipped).
- `stage_ready`  in  NUM_STAGES  per-stage done handshake, sampled only for the active stage.
- `flush`  in  1  aborts the current instruction (taken branch).
- `stage_go`  out  NUM_STAGES  one-hot enable for the active stage; all zero when idle.
- `stage_idx`  out  $clog2(NUM_STAGES)  index of the active stage.
- `busy`  out  1  1 while an instruction is in flight.
- `instr_done`  out  1  one-cycle pulse on retirement.
- `retired_count`  out  CNT_W  count of retired instructions.
- `stall_count`  out  CNT_W  count of cycles in which the active stage was not ready.

## Operation
States:
- IDLE: `busy=0`, `stage_go=0`.
- ACTIVE(k): `busy=1`, `stage_go=1<<k`, `stage_idx=k`.

Transitions:
- IDLE with `run=1` → ACTIVE(0) on the next cycle.
- ACTIVE(k) with `flush=1` and k≥1 → ACTIVE(0) if `run=1`, else IDLE.
  - No `instr_done` pulse; `retired_count` is unchanged.
  - `flush` takes priority over `stage_ready`.
- ACTIVE(0) with `flush=1` → `flush` is ignored.
- ACTIVE(k) with `stage_ready[k]=1` → ACTIVE(j), where j is the lowest index >k with `stage_skip[j]=0`.
  - `stage_skip` is sampled in the same cycle as `stage_ready`.
  - If no such j exists, the instruction retires:
    - `instr_done` pulses and `retired_count` increments.
    - Next state is ACTIVE(0) if `run=1`, else IDLE.
- ACTIVE(k) with `stage_ready[k]=0` and no flush → remain in ACTIVE(k); `stall_count` increments.
- `run` deasserting mid-instruction does not abort the instruction; it only takes effect at retirement or flush.

Counters:
- Both counters wrap from 2^CNT_W−1 to 0 with no saturation.
- Retirement and stall are mutually exclusive in any cycle, so each counter advances by at most 1 per cycle.

Reset:
- All outputs 0, state IDLE, both counters 0.
- Reset mid-instruction abandons the instruction without an `instr_done` pulse.

## Timing
- `stage_go`, `stage_idx`, `busy`, `instr_done` and both counters are registered; none has a combinational path from any input.
- Minimum one cycle per active stage.
- No skips, all ready: an instruction occupies exactly `NUM_STAGES` cycles and back-to-back instructions have no bubble.
  - `instr_done` is high in the cycle after the last stage, coincident with ACTIVE(0) of the next instruction, or with IDLE.
- IDLE→ACTIVE(0) latency: 1 cycle after `run` is sampled high.
- Flush: ACTIVE(0) is entered in the cycle following the flush sample.
- Cycles for one instruction = number of unskipped stages + total cycles with ready low.

## Structure
- Shared package `cpu_ctrl_pkg` contains:
  - stage index constants `STAGE_IF=0`, `STAGE_ID=1`, `STAGE_EX=2`, `STAGE_MEM=3`, `STAGE_WB=4`;
  - state enum {IDLE, ACTIVE};
  - the default counter width.
- Sub-module `next_stage_finder`: combinational priority encoder. Inputs are the current index and the skip mask; outputs are the next index and a `wrap` flag.

## Test plan
- `run=1`, skip=0, ready=all 1s, NUM_STAGES=5 → `stage_go` sequence 01,02,04,08,10,01; `instr_done` pulses every 5 cycles; `retired_count` = 2 after 10 cycles.
- skip=5'b01000 (MEM), all ready → `stage_go` 01,02,04,10 repeating; `instr_done` every 4 cycles.
- `stage_ready[3]` held low for 3 cycles during MEM → `stage_go`=08 for 4 cycles; `stall_count`=3; `instr_done` delayed by 3 cycles.
- `flush` pulsed in EX → next cycle `stage_go`=01, no `instr_done`, `retired_count` unchanged. A separate `flush` pulsed in IF is ignored.
- `run` dropped during ID → instruction completes, `instr_done` pulses, then `busy=0` and `stage_go=0`.
- `retired_count` preloaded near wrap via force to 2^32−1 → next retirement gives 0.
- `nreset` asserted in WB → next cycle all outputs 0 and counters 0.
